// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: shares one AXI4 write port (AW/W/B) between two write masters.
// Requester 0 is camera_adaptor frame writes, requester 1 is accelerator write-back.
// Arbitration is per burst with round-robin order. A granted burst is carried
// through address, data and response before the next decision is made.
// Optional statistics counters are enabled with `define DDR_ARB_STATS_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick a winner from s_awvalid, latch its AW fields
// ADDR  | m_axi_awvalid held; awready is passed through to the owner
// DATA  | W channel muxed from the owner until its wlast beat is taken
// RESP  | B channel routed to the owner; handshake releases the grant
module ddr_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [2*AW-1:0]   s_awaddr,
  input  logic [15:0]       s_awlen,
  input  logic [1:0]        s_awvalid,
  output logic [1:0]        s_awready,
  input  logic [2*DW-1:0]   s_wdata,
  input  logic [2*DW/8-1:0] s_wstrb,
  input  logic [1:0]        s_wlast,
  input  logic [1:0]        s_wvalid,
  output logic [1:0]        s_wready,
  output logic [1:0]        s_bresp,
  output logic [1:0]        s_bvalid,
  input  logic [1:0]        s_bready,
  output logic [AW-1:0]     m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DW-1:0]     m_axi_wdata,
  output logic [DW/8-1:0]   m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [1:0]        grant
`ifdef DDR_ARB_STATS_EN
  ,
  output logic [31:0]       burst_cnt0,
  output logic [31:0]       burst_cnt1,
  output logic [15:0]       err_cnt
`endif
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state;
  logic   rr_last;   // index of the requester that owned the previous burst
  logic   gsel;      // index of the current owner (valid while grant != 0)
  logic   win;       // index of the requester that wins in IDLE
  logic   b_hs;

  assign gsel = grant[1];
  // With both requesting, the one that did not go last wins; otherwise the sole requester.
  assign win  = (&s_awvalid) ? ~rr_last : s_awvalid[1];
  assign b_hs = m_axi_bvalid && m_axi_bready;

  assign m_axi_awsize  = 3'($clog2(SW));
  assign m_axi_awburst = 2'b01;

  // Burst-level FSM: owner selection, registered AW fields and AW valid.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      grant         <= 2'b00;
      rr_last       <= 1'b1;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_awvalid) begin
            grant         <= win ? 2'b10 : 2'b01;
            m_axi_awaddr  <= win ? s_awaddr[AW +: AW] : s_awaddr[0 +: AW];
            m_axi_awlen   <= win ? s_awlen[8 +: 8] : s_awlen[0 +: 8];
            m_axi_awvalid <= 1'b1;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (m_axi_wvalid && m_axi_wready && m_axi_wlast) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_last <= gsel;
            grant   <= 2'b00;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Channel routing: awready, W and B are steered to/from the owner only.
  always_comb begin
    s_awready    = 2'b00;
    s_wready     = 2'b00;
    s_bvalid     = 2'b00;
    s_bresp      = m_axi_bresp;
    m_axi_wdata  = gsel ? s_wdata[DW +: DW] : s_wdata[0 +: DW];
    m_axi_wstrb  = gsel ? s_wstrb[SW +: SW] : s_wstrb[0 +: SW];
    m_axi_wlast  = gsel ? s_wlast[1] : s_wlast[0];
    m_axi_wvalid = 1'b0;
    m_axi_bready = 1'b0;
    case (state)
      ADDR: s_awready[gsel] = m_axi_awready;
      DATA: begin
        m_axi_wvalid   = s_wvalid[gsel];
        s_wready[gsel] = m_axi_wready;
      end
      RESP: begin
        m_axi_bready   = s_bready[gsel];
        s_bvalid[gsel] = m_axi_bvalid;
      end
      default: ;
    endcase
  end

`ifdef DDR_ARB_STATS_EN
  // Saturating per-requester burst counts and error-response count.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      burst_cnt0 <= '0;
      burst_cnt1 <= '0;
      err_cnt    <= '0;
    end else if (state == RESP && b_hs) begin
      if (!gsel && burst_cnt0 != 32'hFFFF_FFFF) burst_cnt0 <= burst_cnt0 + 32'd1;
      if (gsel && burst_cnt1 != 32'hFFFF_FFFF)  burst_cnt1 <= burst_cnt1 + 32'd1;
      if (m_axi_bresp != 2'b00 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: two master drivers, a DDR slave model
// and a negedge monitor comparing forwarded traffic against per-requester queues.
module tb_ddr_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic areset;
  logic [2*AW-1:0] s_awaddr;
  logic [15:0]     s_awlen;
  logic [1:0]      s_awvalid, s_awready;
  logic [2*DW-1:0] s_wdata;
  logic [2*SW-1:0] s_wstrb;
  logic [1:0]      s_wlast, s_wvalid, s_wready;
  logic [1:0]      s_bresp, s_bvalid, s_bready;
  logic [AW-1:0]   m_axi_awaddr;
  logic [7:0]      m_axi_awlen;
  logic [2:0]      m_axi_awsize;
  logic [1:0]      m_axi_awburst;
  logic            m_axi_awvalid, m_axi_awready;
  logic [DW-1:0]   m_axi_wdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic            m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid, m_axi_bready;
  logic [1:0]      grant;
`ifdef DDR_ARB_STATS_EN
  logic [31:0]     burst_cnt0, burst_cnt1;
  logic [15:0]     err_cnt;
`endif

  ddr_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .grant(grant)
`ifdef DDR_ARB_STATS_EN
    , .burst_cnt0(burst_cnt0), .burst_cnt1(burst_cnt1), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  int n_chk = 0;
  int n_fail = 0;

  beat_t       exp_w0[$], exp_w1[$];
  logic [39:0] exp_aw0[$], exp_aw1[$];
  int          exp_grant[$];

  bit          abort = 1'b0;
  bit          wr_toggle = 1'b0;
  bit          aw_rand = 1'b0;
  logic [1:0]  slave_bresp = 2'b00;
  bit          pend_b = 1'b0;
  bit          hs_b = 1'b0;
  bit          hs_wlast = 1'b0;
  bit          prev_b = 1'b0;
  bit          mon_aw_done = 1'b0;
  int          beats_seen = 0;
  int          gi;
  beat_t       mb;
  logic [39:0] ma;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bdata(input int r, input logic [31:0] a, input int b);
    return a ^ (32'(r) << 28) ^ (32'(b) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [3:0] bstrb(input int r, input int b);
    return 4'((b * 3 + r + 1) & 15);
  endfunction

  // Monitor: all DUT outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (areset) begin
      mon_aw_done = 1'b0;
      hs_b = 1'b0;
      hs_wlast = 1'b0;
      prev_b = 1'b0;
    end else begin
      gi = int'(grant[1]);
      if (prev_b) begin
        check("grant_idle_after_b", grant, 0);
        check("awvalid_idle_after_b", m_axi_awvalid, 0);
      end
      hs_b = m_axi_bvalid && m_axi_bready;
      hs_wlast = 1'b0;
      for (int r = 0; r < 2; r++) begin
        if (m_axi_awvalid && grant[r]) check("awready_pass", s_awready[r], m_axi_awready);
        else if (s_awvalid[r]) check("loser_awready", s_awready[r], 0);
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (gi == 0 && exp_aw0.size() > 0) begin
          ma = exp_aw0.pop_front();
          check("aw_addr0", m_axi_awaddr, ma[31:0]);
          check("aw_len0", m_axi_awlen, ma[39:32]);
        end else if (gi == 1 && exp_aw1.size() > 0) begin
          ma = exp_aw1.pop_front();
          check("aw_addr1", m_axi_awaddr, ma[31:0]);
          check("aw_len1", m_axi_awlen, ma[39:32]);
        end else begin
          check("aw_unexpected", 1, 0);
        end
        if (exp_grant.size() > 0) check("grant_order", grant, 2'b01 << exp_grant.pop_front());
        check("awsize", m_axi_awsize, 3'd2);
        check("awburst", m_axi_awburst, 2'b01);
      end
      if (mon_aw_done) begin
        check("wready_mirror", s_wready[gi], m_axi_wready);
        check("wready_other", s_wready[1-gi], 0);
        check("wvalid_mux", m_axi_wvalid, s_wvalid[gi]);
      end else if (|s_wvalid) begin
        check("wready_blocked", s_wready, 0);
      end
      if (m_axi_wvalid) check("w_after_aw", mon_aw_done, 1);
      if (m_axi_awvalid && m_axi_awready) mon_aw_done = 1'b1;
      else if (m_axi_wvalid && m_axi_wready) begin
        if (gi == 0 && exp_w0.size() > 0) mb = exp_w0.pop_front();
        else if (gi == 1 && exp_w1.size() > 0) mb = exp_w1.pop_front();
        else begin
          mb = '0;
          check("w_unexpected", 1, 0);
        end
        check("w_data", m_axi_wdata, mb.data);
        check("w_strb", m_axi_wstrb, mb.strb);
        check("w_last", m_axi_wlast, mb.last);
        beats_seen++;
        if (m_axi_wlast) begin
          hs_wlast = 1'b1;
          mon_aw_done = 1'b0;
        end
      end
      if (hs_b) begin
        check("bvalid_owner", s_bvalid[gi], 1);
        check("bvalid_other", s_bvalid[1-gi], 0);
        check("bresp_pass", s_bresp, m_axi_bresp);
      end
      prev_b = hs_b;
    end
  end

  // DDR slave model: drives ready/response 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (areset) begin
      m_axi_bvalid = 1'b0;
      pend_b = 1'b0;
    end else begin
      if (hs_b) m_axi_bvalid = 1'b0;
      if (hs_wlast) pend_b = 1'b1;
      if (pend_b) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp = slave_bresp;
        pend_b = 1'b0;
      end
      m_axi_wready = wr_toggle ? ~m_axi_wready : 1'b1;
      m_axi_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic master(input int r, input logic [31:0] addr, input logic [7:0] len, input int w_early);
    beat_t bt;
    int t;
    if (r == 0) exp_aw0.push_back({len, addr}); else exp_aw1.push_back({len, addr});
    for (int b = 0; b <= int'(len); b++) begin
      bt.data = bdata(r, addr, b);
      bt.strb = bstrb(r, b);
      bt.last = (b == int'(len));
      if (r == 0) exp_w0.push_back(bt); else exp_w1.push_back(bt);
    end
    fork
      begin
        int ta;
        ta = 0;
        repeat (w_early) begin @(posedge clk); #1; end
        s_awaddr[r*AW +: AW] = addr;
        s_awlen[r*8 +: 8] = len;
        s_awvalid[r] = 1'b1;
        while (!abort) begin
          @(negedge clk);
          if (abort) break;
          if (s_awready[r]) begin @(posedge clk); #1; break; end
          ta++;
          if (ta > 2000) begin check("aw_timeout", 0, 1); break; end
        end
        s_awvalid[r] = 1'b0;
      end
      begin
        int tw;
        for (int b = 0; b <= int'(len) && !abort; b++) begin
          s_wdata[r*DW +: DW] = bdata(r, addr, b);
          s_wstrb[r*SW +: SW] = bstrb(r, b);
          s_wlast[r] = (b == int'(len));
          s_wvalid[r] = 1'b1;
          tw = 0;
          while (!abort) begin
            @(negedge clk);
            if (abort) break;
            if (s_wready[r]) begin @(posedge clk); #1; break; end
            tw++;
            if (tw > 2000) begin check("w_timeout", 0, 1); abort = 1'b1; end
          end
        end
        s_wvalid[r] = 1'b0;
        s_wlast[r] = 1'b0;
      end
    join
    t = 0;
    while (!abort) begin
      @(negedge clk);
      if (abort) break;
      if (s_bvalid[r] && s_bready[r]) begin
        check("b_resp_seen", s_bresp, slave_bresp);
        @(posedge clk); #1;
        break;
      end
      t++;
      if (t > 2000) begin check("b_timeout", 0, 1); break; end
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    areset = 1'b1;
    s_awaddr = '0; s_awlen = '0; s_awvalid = '0;
    s_wdata = '0; s_wstrb = '0; s_wlast = '0; s_wvalid = '0;
    s_bready = 2'b11;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_awvalid", m_axi_awvalid, 0);
    check("rst_wvalid", m_axi_wvalid, 0);
    check("rst_bready", m_axi_bready, 0);
    check("rst_s_awready", s_awready, 0);
    check("rst_s_wready", s_wready, 0);
    check("rst_s_bvalid", s_bvalid, 0);
    check("rst_awaddr", m_axi_awaddr, 0);
    check("rst_awlen", m_axi_awlen, 0);
    areset = 1'b0;
    @(posedge clk); #1;

    // single requester, 4 beats
    exp_grant.push_back(0);
    master(0, 32'h0000_1000, 8'd3, 0);

    // contention from reset: alternating order
    do_reset();
    exp_grant.push_back(0); exp_grant.push_back(1);
    exp_grant.push_back(0); exp_grant.push_back(1);
    fork
      begin master(0, 32'h0000_2000, 8'd0, 0); master(0, 32'h0000_2100, 8'd0, 0); end
      begin master(1, 32'h0000_3000, 8'd0, 0); master(1, 32'h0000_3100, 8'd0, 0); end
    join
    check("contention_grants_done", exp_grant.size(), 0);

    // W backpressure on a 16-beat burst with random awready
    wr_toggle = 1'b1; aw_rand = 1'b1;
    exp_grant.push_back(1);
    master(1, 32'h0000_4000, 8'd15, 0);
    wr_toggle = 1'b0; aw_rand = 1'b0;

    // W presented 5 cycles before AW
    exp_grant.push_back(1);
    master(1, 32'h0000_5000, 8'd2, 5);

    // reset in the middle of the data phase
    beats_seen = 0;
    exp_grant.push_back(0);
    fork
      master(0, 32'h0000_6000, 8'd7, 0);
      begin
        t = 0;
        while (beats_seen < 2 && t < 2000) begin @(negedge clk); t++; end
        check("mid_rst_beats_reached", beats_seen >= 2, 1);
        @(posedge clk); #1;
        areset = 1'b1;
        #1;
        check("mid_rst_awvalid", m_axi_awvalid, 0);
        check("mid_rst_wvalid", m_axi_wvalid, 0);
        check("mid_rst_bready", m_axi_bready, 0);
        check("mid_rst_grant", grant, 0);
        abort = 1'b1;
      end
    join
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0;
    exp_w0.delete(); exp_w1.delete(); exp_aw0.delete(); exp_aw1.delete(); exp_grant.delete();
    abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk); #1;
    exp_grant.push_back(0);
    master(0, 32'h0000_7000, 8'd3, 0);

    // mixed bursts with one error response
    do_reset();
    exp_grant.push_back(0); exp_grant.push_back(0); exp_grant.push_back(0);
    exp_grant.push_back(1); exp_grant.push_back(1);
    master(0, 32'h0000_8000, 8'd1, 0);
    slave_bresp = 2'b10;
    master(0, 32'h0000_8100, 8'd0, 0);
    slave_bresp = 2'b00;
    master(0, 32'h0000_8200, 8'd2, 0);
    master(1, 32'h0000_9000, 8'd1, 0);
    master(1, 32'h0000_9100, 8'd0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef DDR_ARB_STATS_EN
    check("burst_cnt0", burst_cnt0, 3);
    check("burst_cnt1", burst_cnt1, 2);
    check("err_cnt", err_cnt, 1);
`endif
    check("final_grant", grant, 0);
    check("sb_empty_w0", exp_w0.size(), 0);
    check("sb_empty_w1", exp_w1.size(), 0);
    check("sb_empty_aw", exp_aw0.size() + exp_aw1.size(), 0);
    check("sb_empty_grant", exp_grant.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
